// File: rtl/ps2_terminal_top.sv
// rtl/ps2_terminal_top.sv - PS/2 keyboard password terminal
// Oversampled PS/2 receiver, make-code filter and password progress checker.
module ps2_terminal_top #(
   parameter int                    PASS_W      = 4,
   parameter logic [PASS_W*8-1:0]   PASS_CODES  = {8'h2D, 8'h24, 8'h3C, 8'h2C},
   parameter int                    TIMEOUT_CYC = 2000
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              keyboard_clk,
   input  logic              data,
   output logic [PASS_W-1:0] leds
);

   localparam int PW = $clog2(PASS_W + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

   logic              kclk_s1_q, kclk_s2_q, kclk_prev_q;
   logic              data_s1_q, data_s2_q;
   rx_state_t         state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_q, par_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              byte_valid_q, byte_valid_d;
   logic [7:0]        byte_q, byte_d;
   logic              brk_q, brk_d;
   logic              key_valid_q, key_valid_d;
   logic [7:0]        key_q, key_d;
   logic [PW-1:0]     p_q, p_d;
   logic [PASS_W-1:0] leds_q, leds_d;
   logic              fall;
   logic [7:0]        exp_code;

   assign fall = kclk_prev_q & ~kclk_s2_q;
   assign leds = leds_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         kclk_s1_q    <= 1'b0;
         kclk_s2_q    <= 1'b0;
         kclk_prev_q  <= 1'b0;
         data_s1_q    <= 1'b0;
         data_s2_q    <= 1'b0;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         timer_q      <= '0;
         byte_valid_q <= 1'b0;
         byte_q       <= '0;
         brk_q        <= 1'b0;
         key_valid_q  <= 1'b0;
         key_q        <= '0;
         p_q          <= '0;
         leds_q       <= '0;
      end else begin
         kclk_s1_q    <= keyboard_clk;
         kclk_s2_q    <= kclk_s1_q;
         kclk_prev_q  <= kclk_s2_q;
         data_s1_q    <= data;
         data_s2_q    <= data_s1_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         timer_q      <= timer_d;
         byte_valid_q <= byte_valid_d;
         byte_q       <= byte_d;
         brk_q        <= brk_d;
         key_valid_q  <= key_valid_d;
         key_q        <= key_d;
         p_q          <= p_d;
         leds_q       <= leds_d;
      end
   end

   // Frame receiver; the timeout only applies while a frame is in progress.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      timer_d      = timer_q;
      byte_valid_d = 1'b0;
      byte_d       = byte_q;
      if (state_q != S_IDLE) begin
         if (fall) begin
            timer_d = '0;
         end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
            timer_d = '0;
            state_d = S_IDLE;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
      case (state_q)
         S_IDLE: begin
            if (fall && !data_s2_q) begin
               state_d = S_DATA;
               cnt_d   = '0;
               timer_d = '0;
            end
         end
         S_DATA: begin
            if (fall) begin
               shift_d = {data_s2_q, shift_q[7:1]};
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (fall) begin
               par_d   = data_s2_q;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (fall) begin
               byte_valid_d = data_s2_q & (^{shift_q, par_q});
               byte_d       = shift_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Make-code filter: drop E0 prefixes and the code following each F0.
   always_comb begin
      brk_d       = brk_q;
      key_valid_d = 1'b0;
      key_d       = key_q;
      if (byte_valid_q) begin
         if (byte_q == 8'hE0) begin
            brk_d = brk_q;
         end else if (byte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (brk_q) begin
            brk_d = 1'b0;
         end else begin
            key_valid_d = 1'b1;
            key_d       = byte_q;
         end
      end
   end

   // Password progress; leds is registered from the next progress value.
   always_comb begin
      exp_code = 8'h00;
      for (int i = 0; i < PASS_W; i++) begin
         if (int'(p_q) == i) exp_code = PASS_CODES[i*8 +: 8];
      end
      p_d = p_q;
      if (key_valid_q && int'(p_q) < PASS_W) begin
         if (key_q == exp_code) p_d = p_q + PW'(1);
         else if (key_q == PASS_CODES[7:0]) p_d = PW'(1);
         else p_d = '0;
      end
      leds_d = '0;
      for (int i = 0; i < PASS_W; i++) begin
         leds_d[i] = (i < int'(p_d));
      end
   end

endmodule

// File: tb/tb_ps2_terminal_top.sv
// tb/tb_ps2_terminal_top.sv - directed bench for the PS/2 password terminal
`timescale 1ns/1ps
module tb_ps2_terminal_top;

   logic       sys_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       keyboard_clk = 1'b1;
   logic       data = 1'b1;
   logic [3:0] leds;

   int errors = 0;
   int checks = 0;

   ps2_terminal_top #(
      .PASS_W(4),
      .PASS_CODES({8'h2D, 8'h24, 8'h3C, 8'h2C}),
      .TIMEOUT_CYC(200)
   ) dut (
      .sys_clk(sys_clk),
      .rst_n(rst_n),
      .keyboard_clk(keyboard_clk),
      .data(data),
      .leds(leds)
   );

   always #1 sys_clk = ~sys_clk;

   typedef struct {
      bit         rst;
      logic [7:0] code;
      bit         bad_par;
      bit         stop;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [10:0] mk_frame(input logic [7:0] code, input bit bad_par, input bit stop);
      logic par;
      par = ~(^code) ^ bad_par;
      return {stop, par, code, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int from, input int to);
      for (int i = from; i <= to; i++) begin
         data = f[i];
         #10 keyboard_clk = 1'b0;
         #10 keyboard_clk = 1'b1;
      end
   endtask

   task automatic chk(input string nm, input logic [3:0] exp);
      checks++;
      if (leds !== exp) begin
         errors++;
         $display("FAIL %s leds=%b expected=%b", nm, leds, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #4 chk("reset_state", 4'b0000);
      rst_n = 1'b1;
      #10;
   endtask

   // Sends a frame and samples leds 6 sys_clk cycles after the stop-bit falling edge.
   task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit stop);
      send_bits(mk_frame(code, bad_par, stop), 0, 10);
      #2;
   endtask

   initial begin
      vecs.push_back('{1, 8'h2C, 0, 1, 4'b0001});
      vecs.push_back('{0, 8'h3C, 0, 1, 4'b0011});
      vecs.push_back('{0, 8'h24, 0, 1, 4'b0111});
      vecs.push_back('{0, 8'h2D, 0, 1, 4'b1111});
      vecs.push_back('{0, 8'h1C, 0, 1, 4'b1111});
      vecs.push_back('{1, 8'h2C, 0, 1, 4'b0001});
      vecs.push_back('{0, 8'h3C, 0, 1, 4'b0011});
      vecs.push_back('{0, 8'h1C, 0, 1, 4'b0000});
      vecs.push_back('{0, 8'h2C, 0, 1, 4'b0001});
      vecs.push_back('{0, 8'h2C, 0, 1, 4'b0001});
      vecs.push_back('{1, 8'h2C, 1, 1, 4'b0000});
      vecs.push_back('{0, 8'h2C, 0, 0, 4'b0000});
      vecs.push_back('{1, 8'hF0, 0, 1, 4'b0000});
      vecs.push_back('{0, 8'h2C, 0, 1, 4'b0000});
      vecs.push_back('{0, 8'hE0, 0, 1, 4'b0000});
      vecs.push_back('{0, 8'h2C, 0, 1, 4'b0001});

      #10;
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop);
         chk($sformatf("vec%0d_code%02h", i, vecs[i].code), vecs[i].exp);
         #40;
      end

      // Partial frame abandoned long enough to time out, then a clean frame.
      do_reset();
      send_bits(mk_frame(8'h2C, 0, 1), 0, 4);
      data = 1'b1;
      #600 chk("timeout_partial", 4'b0000);
      send_frame(8'h2C, 0, 1);
      chk("timeout_recover", 4'b0001);
      #40;

      // Reset in the middle of the third key's frame.
      do_reset();
      send_frame(8'h2C, 0, 1);
      #40;
      send_frame(8'h3C, 0, 1);
      chk("midrst_pre", 4'b0011);
      #40;
      send_bits(mk_frame(8'h24, 0, 1), 0, 3);
      rst_n = 1'b0;
      #2 chk("midrst_immediate", 4'b0000);
      #2 rst_n = 1'b1;
      #10;
      send_bits(mk_frame(8'h24, 0, 1), 4, 10);
      data = 1'b1;
      #600 chk("midrst_tail", 4'b0000);
      send_frame(8'h2C, 0, 1);
      chk("midrst_recover", 4'b0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_terminal_top.md
Name: ps2_terminal_top

Overview:
- PS/2 keyboard password terminal.
- Receives PS/2 device-to-host frames on keyboard_clk/data, oversampled in the sys_clk domain, and decodes make codes (break and extended codes are filtered out).
- Compares the key sequence against a fixed password of PASS_W scan codes; leds shows entry progress as a thermometer code.
- Top-level block, driven directly by the keyboard pins.

Parameters:
- PASS_W, default 4: number of keys in the password; also the leds width. Legal range 1..16.
- PASS_CODES, default {8'h2D,8'h24,8'h3C,8'h2C}: packed PASS_W*8-bit password. Byte 0 (bits 7:0) is the first key.
- TIMEOUT_CYC, default 2000: sys_clk cycles without a keyboard_clk falling edge before a partial frame is dropped.

Ports:
- sys_clk, input, 1: system clock; the only clock in the design.
- rst_n, input, 1: asynchronous active-low reset.
- keyboard_clk, input, 1: PS/2 clock from the keyboard. Treated as asynchronous data, never as a clock.
- data, input, 1: PS/2 data line. Asynchronous.
- leds, output, PASS_W: password progress; bit k lit means key k was entered correctly.

Behaviour:
- Single clock: sys_clk. Reset is asynchronous and active-low on rst_n. All flops clear on reset; leds = 0.
- keyboard_clk and data each pass through a 2-flop synchronizer.
- A falling edge is detected when the synchronized previous value is 1 and the current value is 0.
- The data bit is sampled on the sys_clk cycle in which the falling edge is detected.
- Frame format, 11 bits, one per falling edge:
  - start bit = 0
  - 8 data bits, LSB first
  - odd parity bit
  - stop bit = 1
- Receiver states:
  - IDLE: on an edge with data = 0, go to DATA; an edge with data = 1 is ignored.
  - DATA: shift in 8 bits, then go to PARITY.
  - PARITY: capture the bit, go to STOP.
  - STOP: sample the bit, then return to IDLE.
- Frame validity:
  - Valid when popcount(data bits + parity) is odd and stop = 1.
  - A valid frame raises a 1-cycle byte_valid strobe with the byte on the sys_clk cycle after stop sampling.
  - An invalid frame is silently discarded; there is no strobe.
- Timeout: in any non-IDLE state, if TIMEOUT_CYC cycles pass without an edge, return to IDLE and discard the partial frame.
- Code filter, applied to each valid byte:
  - 8'hE0 is ignored (extended prefix; the following code is treated as a normal code).
  - 8'hF0 sets break_pending.
  - If break_pending is set, the byte is discarded and break_pending clears (key releases are never counted).
  - Otherwise the byte is a key event.
- Password checker, with progress counter p in 0..PASS_W:
  - Key event, p < PASS_W, key == PASS_CODES[p]: p <= p+1.
  - Key event, p < PASS_W, key mismatch, key == PASS_CODES[0]: p <= 1.
  - Key event, p < PASS_W, any other mismatch: p <= 0.
  - p == PASS_W (unlocked): all key events are ignored; the state holds until rst_n.
- leds is registered: leds[i] = (i < p).
- leds updates on the cycle after the key-event strobe.
- Total latency from the stop-bit falling edge on the pin to the leds change is at most 6 sys_clk cycles.
- Reset mid-frame clears the receiver, break_pending and p immediately. The remainder of the interrupted frame produces no key event:
  - trailing bits that are 1 are ignored in IDLE;
  - a later 0 bit starts a frame that fails parity, fails the stop check, or times out.
- Assumption: sys_clk is at least 8x faster than keyboard_clk.

Test Plan:
- Reset, sys_clk period 2, keyboard_clk period 20, send valid frame 8'h2C -> leds = 4'b0001 within 6 sys_clk cycles of the stop edge.
- Send 2C, 3C, 24, 2D in order -> leds = 0001, 0011, 0111, 1111; then send 1C -> leds stays 1111.
- Send 2C, 3C, then 1C -> leds goes 0011 then 0000; send 2C, 2C -> leds 0001 (restart rule).
- Send 2C with the parity bit inverted, or with stop = 0 -> leds stays 0000.
- Send F0, 2C (break) -> leds 0000. Send E0, 2C -> leds 0001.
- Stop after 5 bits for more than TIMEOUT_CYC cycles, then send a full 2C frame -> leds 0001.
- Assert rst_n mid-frame at leds = 0011 -> leds 0000 immediately, and the interrupted frame produces no event.
